// File: rtl/ddr3_ram_arbiter_if.sv
// ddr3_ram_arbiter_if: requester-side and core-side native RAM bus bundle for the arbiter.
interface ddr3_ram_arbiter_if #(parameter int PORTS = 2);
  logic [PORTS*16-1:0]  inport_wr_i;
  logic [PORTS-1:0]     inport_rd_i;
  logic [PORTS*32-1:0]  inport_addr_i;
  logic [PORTS*128-1:0] inport_write_data_i;
  logic [PORTS*16-1:0]  inport_req_id_i;
  logic [PORTS-1:0]     inport_accept_o;
  logic [PORTS-1:0]     inport_ack_o;
  logic [PORTS-1:0]     inport_error_o;
  logic [127:0]         inport_read_data_o;
  logic [15:0]          inport_resp_id_o;
  logic [15:0]          outport_wr_o;
  logic                 outport_rd_o;
  logic [31:0]          outport_addr_o;
  logic [127:0]         outport_write_data_o;
  logic [15:0]          outport_req_id_o;
  logic                 outport_accept_i;
  logic                 outport_ack_i;
  logic                 outport_error_i;
  logic [127:0]         outport_read_data_i;
  logic [15:0]          outport_resp_id_i;
  logic                 err_unrouted_o;
  logic                 err_underflow_o;
  modport slave (
    input  inport_wr_i, inport_rd_i, inport_addr_i, inport_write_data_i, inport_req_id_i,
           outport_accept_i, outport_ack_i, outport_error_i, outport_read_data_i, outport_resp_id_i,
    output inport_accept_o, inport_ack_o, inport_error_o, inport_read_data_o, inport_resp_id_o,
           outport_wr_o, outport_rd_o, outport_addr_o, outport_write_data_o, outport_req_id_o,
           err_unrouted_o, err_underflow_o
  );
  modport master (
    output inport_wr_i, inport_rd_i, inport_addr_i, inport_write_data_i, inport_req_id_i,
           outport_accept_i, outport_ack_i, outport_error_i, outport_read_data_i, outport_resp_id_i,
    input  inport_accept_o, inport_ack_o, inport_error_o, inport_read_data_o, inport_resp_id_o,
           outport_wr_o, outport_rd_o, outport_addr_o, outport_write_data_o, outport_req_id_o,
           err_unrouted_o, err_underflow_o
  );
endinterface

// File: rtl/ddr3_ram_arbiter.sv
// ddr3_ram_arbiter: N-port RR/fixed-priority arbiter with ID tagging, outstanding limit and routed responses.
module ddr3_ram_arbiter #(
  parameter int PORTS = 2,
  parameter int ARB_MODE = 0,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic clk_i,
  input logic rst_i,
  ddr3_ram_arbiter_if.slave bus
);
  typedef enum logic {IDLE, LOCK} st_e;
  st_e st_q, st_d;
  logic [2:0] gnt_q, gnt_d, ptr_q, ptr_d, g, k;
  logic gv, routed;
  logic [3:0] cnt_q [PORTS];
  logic [3:0] cnt_d [PORTS];
  logic [PORTS-1:0] req, elig, acc, hit, ack_q, ack_d, err_q, err_d;
  logic [127:0] rdata_q, rdata_d;
  logic [12:0] rid_q, rid_d;
  logic unr_q, unr_d, und_q, und_d;
  // ptr_q holds the next RR search start (last grant + 1), so reset starts at port 0
  always_comb begin
    req = '0;
    elig = '0;
    g = '0;
    gv = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      req[p] = |bus.inport_wr_i[p*16+:16] | bus.inport_rd_i[p];
      elig[p] = req[p] && cnt_q[p] < 4'(MAX_OUTSTANDING);
    end
    if (st_q == LOCK) begin
      g = gnt_q;
      gv = 1'b1;
    end else
      for (int i = 0; i < PORTS; i++)
        for (int p = 0; p < PORTS; p++)
          if (!gv && elig[p] && p == ((ARB_MODE != 0) ? i : (int'(ptr_q) + i) % PORTS)) begin
            g = 3'(p);
            gv = 1'b1;
          end
    gv = gv & ~rst_i;
  end
  always_comb begin
    bus.outport_wr_o = '0;
    bus.outport_rd_o = 1'b0;
    bus.outport_addr_o = '0;
    bus.outport_write_data_o = '0;
    bus.outport_req_id_o = '0;
    acc = '0;
    for (int p = 0; p < PORTS; p++)
      if (gv && g == 3'(p)) begin
        bus.outport_wr_o = bus.inport_wr_i[p*16+:16];
        bus.outport_rd_o = bus.inport_rd_i[p];
        bus.outport_addr_o = bus.inport_addr_i[p*32+:32];
        bus.outport_write_data_o = bus.inport_write_data_i[p*128+:128];
        bus.outport_req_id_o = {g, bus.inport_req_id_i[p*16+:13]};
        acc[p] = bus.outport_accept_i;
      end
  end
  always_comb begin
    k = bus.outport_resp_id_i[15:13];
    routed = bus.outport_ack_i && {29'd0, k} < PORTS;
    st_d = (gv && !bus.outport_accept_i) ? LOCK : IDLE;
    gnt_d = g;
    ptr_d = (gv && bus.outport_accept_i) ? 3'((int'(g) + 1) % PORTS) : ptr_q;
    hit = '0;
    und_d = und_q;
    for (int p = 0; p < PORTS; p++) begin
      hit[p] = routed && k == 3'(p);
      cnt_d[p] = cnt_q[p] + 4'(acc[p]) - 4'(hit[p] && cnt_q[p] != 4'd0);
      und_d = und_d | (hit[p] && cnt_q[p] == 4'd0);
    end
    ack_d = hit;
    err_d = hit & {PORTS{bus.outport_error_i}};
    unr_d = unr_q | (bus.outport_ack_i && !routed);
    rdata_d = routed ? bus.outport_read_data_i : rdata_q;
    rid_d = routed ? bus.outport_resp_id_i[12:0] : rid_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q <= IDLE;
      gnt_q <= '0;
      ptr_q <= '0;
      ack_q <= '0;
      err_q <= '0;
      rdata_q <= '0;
      rid_q <= '0;
      unr_q <= 1'b0;
      und_q <= 1'b0;
      for (int p = 0; p < PORTS; p++) cnt_q[p] <= '0;
    end else begin
      st_q <= st_d;
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
      ack_q <= ack_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      rid_q <= rid_d;
      unr_q <= unr_d;
      und_q <= und_d;
      for (int p = 0; p < PORTS; p++) cnt_q[p] <= cnt_d[p];
    end
  end
  assign bus.inport_accept_o = acc;
  assign bus.inport_ack_o = ack_q;
  assign bus.inport_error_o = err_q;
  assign bus.inport_read_data_o = rdata_q;
  assign bus.inport_resp_id_o = {3'b000, rid_q};
  assign bus.err_unrouted_o = unr_q;
  assign bus.err_underflow_o = und_q;
endmodule
